// File: rtl/sram_controller_pkg.sv
// Shared widths, FSM encodings and address mapping for the 16-bit SRAM controller.
package sram_controller_pkg;

  localparam int REGISTER_LEN      = 32;
  localparam int SRAM_ADDR_LEN     = 18;
  localparam int SRAM_DATA_LEN     = 16;
  localparam int DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOW  = 3'd1,
    S_HIGH = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } sram_state_t;

  // Word offset from the window base, expressed as the even halfword index;
  // addresses below the base wrap modulo the SRAM address space.
  function automatic logic [SRAM_ADDR_LEN-1:0] halfword_base(
    input logic [REGISTER_LEN-1:0] addr,
    input logic [REGISTER_LEN-1:0] base_addr
  );
    logic [REGISTER_LEN-1:0] word_off;
    word_off = (addr - base_addr) >> 2;
    return SRAM_ADDR_LEN'(word_off << 1);
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Load/enable down-counter that flags when the settle period has elapsed.
module sram_wait_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// 32-bit load/store front end for a 16-bit asynchronous SRAM (two halfword accesses).
// Optional settle cycles after the access are enabled by defining SRAM_WAIT_STATES_EN.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int          WAIT_CYCLES = 3,
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REGISTER_LEN-1:0]  address,
  input  logic [REGISTER_LEN-1:0]  WriteData,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  output logic [REGISTER_LEN-1:0]  ReadData,
  output logic                     ready,
  inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_UB_N,
  output logic                     SRAM_LB_N
);

  if (WAIT_CYCLES < 0) begin : g_bad_wait_cycles
    $error("sram_controller: WAIT_CYCLES must be non-negative");
  end

  sram_state_t              state;
  logic                     op_write;
  logic                     dq_oe;
  logic [SRAM_DATA_LEN-1:0] dq_out;
  logic [SRAM_DATA_LEN-1:0] wdata_hi;
  logic                     start;

  assign start = (state == S_IDLE) && (MemRead || MemWrite);

`ifdef SRAM_WAIT_STATES_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  logic cnt_done;

  // Loaded with N-1 while in HIGH so WAIT lasts exactly N cycles.
  sram_wait_counter #(
    .WIDTH(CNT_W)
  ) u_wait_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_HIGH),
    .en      (state == S_WAIT),
    .load_val(CNT_W'(WAIT_CYCLES - 1)),
    .done    (cnt_done)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_write  <= 1'b0;
      dq_oe     <= 1'b0;
      ReadData  <= '0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          // A write wins when both strobes are raised together.
          if (start) begin
            state     <= S_LOW;
            op_write  <= MemWrite;
            dq_oe     <= MemWrite;
            SRAM_ADDR <= halfword_base(address, 32'(BASE_ADDR));
            SRAM_WE_N <= ~MemWrite;
            SRAM_OE_N <= MemWrite;
          end
        end
        S_LOW: begin
          state     <= S_HIGH;
          SRAM_ADDR <= SRAM_ADDR + SRAM_ADDR_LEN'(1);
          if (!op_write) ReadData[15:0] <= SRAM_DQ;
        end
        S_HIGH: begin
          dq_oe     <= 1'b0;
          SRAM_WE_N <= 1'b1;
          SRAM_OE_N <= 1'b1;
          if (!op_write) ReadData[31:16] <= SRAM_DQ;
`ifdef SRAM_WAIT_STATES_EN
          state <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
`else
          state <= S_DONE;
`endif
        end
`ifdef SRAM_WAIT_STATES_EN
        S_WAIT: begin
          if (cnt_done) state <= S_DONE;
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Bus data path carries no reset; it is only visible while dq_oe is set.
  always_ff @(posedge clk) begin
    if (start) begin
      dq_out   <= WriteData[15:0];
      wdata_hi <= WriteData[31:16];
    end else if (state == S_LOW) begin
      dq_out <= wdata_hi;
    end
  end

  assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DATA_LEN{1'bz}};
  assign ready     = (state == S_DONE) || ((state == S_IDLE) && !MemRead && !MemWrite);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioral asynchronous SRAM on a pulled-up bus.
module tb_sram_controller;

`ifdef SRAM_WAIT_STATES_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int NCYC = LAT + 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] WriteData = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ReadData;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:262143];

  logic        r_ready [0:NCYC-1];
  logic [17:0] r_addr  [0:NCYC-1];
  logic        r_we    [0:NCYC-1];
  logic        r_oe    [0:NCYC-1];
  logic [15:0] r_dq    [0:NCYC-1];
  logic [31:0] r_rd    [0:NCYC-1];

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .address(address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N),
    .SRAM_LB_N(SRAM_LB_N)
  );

  pullup (sram_dq);
  assign sram_dq = (!SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR] : 16'bz;

  always @(posedge clk) begin
    if (!SRAM_WE_N) mem[SRAM_ADDR] <= sram_dq;
  end

  task automatic sample_cycle(input int c);
    r_ready[c] = ready;
    r_addr[c]  = SRAM_ADDR;
    r_we[c]    = SRAM_WE_N;
    r_oe[c]    = SRAM_OE_N;
    r_dq[c]    = sram_dq;
    r_rd[c]    = ReadData;
  endtask

  // Request appears in cycle 0; strobes held through DONE, dropped in the following IDLE cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input bit disturb);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; address = a; WriteData = wd;
    #1 sample_cycle(0);
    for (int c = 1; c < NCYC; c++) begin
      @(negedge clk);
      sample_cycle(c);
      if (disturb && c == 1) begin
        address = a + 32'd16; WriteData = ~wd; MemWrite = ~wr; MemRead = ~rd;
      end
      if (c == LAT + 1) begin
        MemRead = 1'b0; MemWrite = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", ReadData, 32'h0); end
    checks++; if (SRAM_ADDR !== 18'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", SRAM_ADDR, 18'h0); end
    checks++; if ({SRAM_WE_N, SRAM_OE_N} !== 2'b11) begin failures++; $display("FAIL reset_we_oe got=%b exp=11", {SRAM_WE_N, SRAM_OE_N}); end
    checks++; if ({SRAM_CE_N, SRAM_UB_N, SRAM_LB_N} !== 3'b000) begin failures++; $display("FAIL reset_ce_ub_lb got=%b exp=000", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}); end
    checks++; if (sram_dq !== 16'hFFFF) begin failures++; $display("FAIL reset_dq_released got=%h exp=%h", sram_dq, 16'hFFFF); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    checks++; if (r_ready[0] !== 1'b0) begin failures++; $display("FAIL wr_ready_c0 got=%b exp=0", r_ready[0]); end
    checks++; if ({r_addr[1], r_dq[1], r_we[1], r_oe[1]} !== {18'h0, 16'hBEEF, 1'b0, 1'b1})
      begin failures++; $display("FAIL wr_low got addr=%h dq=%h we=%b oe=%b exp addr=0 dq=beef we=0 oe=1", r_addr[1], r_dq[1], r_we[1], r_oe[1]); end
    checks++; if ({r_addr[2], r_dq[2], r_we[2], r_oe[2]} !== {18'h1, 16'hDEAD, 1'b0, 1'b1})
      begin failures++; $display("FAIL wr_high got addr=%h dq=%h we=%b oe=%b exp addr=1 dq=dead we=0 oe=1", r_addr[2], r_dq[2], r_we[2], r_oe[2]); end
    checks++; if ({r_addr[3], r_dq[3], r_we[3]} !== {18'h1, 16'hFFFF, 1'b1})
      begin failures++; $display("FAIL wr_after got addr=%h dq=%h we=%b exp addr=1 dq=ffff we=1", r_addr[3], r_dq[3], r_we[3]); end
    checks++; if ({r_ready[LAT-1], r_ready[LAT]} !== 2'b01)
      begin failures++; $display("FAIL wr_ready_latency got=%b%b exp=01", r_ready[LAT-1], r_ready[LAT]); end
    checks++; if ({mem[1], mem[0]} !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_mem got=%h exp=%h", {mem[1], mem[0]}, 32'hDEADBEEF); end
    checks++; if (r_rd[LAT] !== 32'h0) begin failures++; $display("FAIL wr_readdata_kept got=%h exp=%h", r_rd[LAT], 32'h0); end
  endtask

  task automatic test_read();
    int oe_low;
    int we_low;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    oe_low = 0; we_low = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (r_oe[c] === 1'b0) oe_low++;
      if (r_we[c] === 1'b0) we_low++;
    end
    checks++; if ({r_oe[1], r_oe[2], r_oe[3]} !== 3'b001) begin failures++; $display("FAIL rd_oe_window got=%b%b%b exp=001", r_oe[1], r_oe[2], r_oe[3]); end
    checks++; if (oe_low != 2) begin failures++; $display("FAIL rd_oe_count got=%0d exp=2", oe_low); end
    checks++; if (we_low != 0) begin failures++; $display("FAIL rd_we_count got=%0d exp=0", we_low); end
    checks++; if ({r_dq[1], r_dq[2]} !== 32'hBEEFDEAD) begin failures++; $display("FAIL rd_bus got=%h exp=%h", {r_dq[1], r_dq[2]}, 32'hBEEFDEAD); end
    checks++; if (r_rd[LAT] !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=%h", r_rd[LAT], 32'hDEADBEEF); end
    checks++; if ({r_ready[LAT-1], r_ready[LAT]} !== 2'b01) begin failures++; $display("FAIL rd_ready_latency got=%b%b exp=01", r_ready[LAT-1], r_ready[LAT]); end
    // Strobe still high in DONE and the following IDLE must not launch another access.
    checks++; if ({r_oe[LAT+1], r_oe[LAT+2], r_ready[LAT+2]} !== 3'b111)
      begin failures++; $display("FAIL rd_no_second_access got oe=%b%b ready=%b exp oe=11 ready=1", r_oe[LAT+1], r_oe[LAT+2], r_ready[LAT+2]); end
  endtask

  task automatic test_both_strobes();
    run_access(1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b0);
    checks++; if ({r_addr[1], r_dq[1], r_we[1], r_oe[1]} !== {18'h2, 16'h5678, 1'b0, 1'b1})
      begin failures++; $display("FAIL both_low got addr=%h dq=%h we=%b oe=%b exp addr=2 dq=5678 we=0 oe=1", r_addr[1], r_dq[1], r_we[1], r_oe[1]); end
    checks++; if ({r_addr[2], r_dq[2], r_we[2]} !== {18'h3, 16'h1234, 1'b0})
      begin failures++; $display("FAIL both_high got addr=%h dq=%h we=%b exp addr=3 dq=1234 we=0", r_addr[2], r_dq[2], r_we[2]); end
    checks++; if ({mem[3], mem[2]} !== 32'h12345678) begin failures++; $display("FAIL both_mem got=%h exp=%h", {mem[3], mem[2]}, 32'h12345678); end
    checks++; if (r_rd[LAT] !== 32'hDEADBEEF) begin failures++; $display("FAIL both_readdata_kept got=%h exp=%h", r_rd[LAT], 32'hDEADBEEF); end
  endtask

  task automatic test_wrap();
    // 1000-1024 = -24 bytes = -6 words = -12 halfwords -> 0x40000-12.
    run_access(1'b0, 1'b1, 32'd1000, 32'hCAFEF00D, 1'b0);
    checks++; if ({r_addr[1], r_addr[2]} !== {18'h3FFF4, 18'h3FFF5})
      begin failures++; $display("FAIL wrap_addr got=%h,%h exp=3fff4,3fff5", r_addr[1], r_addr[2]); end
    checks++; if ({mem[18'h3FFF5], mem[18'h3FFF4]} !== 32'hCAFEF00D)
      begin failures++; $display("FAIL wrap_mem got=%h exp=%h", {mem[18'h3FFF5], mem[18'h3FFF4]}, 32'hCAFEF00D); end
  endtask

  task automatic test_operand_hold();
    run_access(1'b0, 1'b1, 32'd1032, 32'hAAAA5555, 1'b1);
    checks++; if ({r_addr[2], r_dq[2], r_we[2], r_oe[2]} !== {18'h5, 16'hAAAA, 1'b0, 1'b1})
      begin failures++; $display("FAIL hold_high got addr=%h dq=%h we=%b oe=%b exp addr=5 dq=aaaa we=0 oe=1", r_addr[2], r_dq[2], r_we[2], r_oe[2]); end
    checks++; if ({mem[5], mem[4]} !== 32'hAAAA5555) begin failures++; $display("FAIL hold_mem got=%h exp=%h", {mem[5], mem[4]}, 32'hAAAA5555); end
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    MemRead = 1'b1; address = 32'd1028;
    @(negedge clk);
    @(negedge clk);
    checks++; if (SRAM_OE_N !== 1'b0) begin failures++; $display("FAIL abort_in_high got oe=%b exp=0", SRAM_OE_N); end
    MemRead = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (ReadData !== 32'h0) begin failures++; $display("FAIL abort_readdata got=%h exp=%h", ReadData, 32'h0); end
    checks++; if ({SRAM_OE_N, SRAM_WE_N, SRAM_ADDR} !== {1'b1, 1'b1, 18'h0})
      begin failures++; $display("FAIL abort_ctrl got oe=%b we=%b addr=%h exp oe=1 we=1 addr=0", SRAM_OE_N, SRAM_WE_N, SRAM_ADDR); end
    checks++; if (sram_dq !== 16'hFFFF) begin failures++; $display("FAIL abort_dq got=%h exp=%h", sram_dq, 16'hFFFF); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({SRAM_OE_N, ready, ReadData} !== {1'b1, 1'b1, 32'h0})
      begin failures++; $display("FAIL abort_no_retry got oe=%b ready=%b rd=%h exp oe=1 ready=1 rd=0", SRAM_OE_N, ready, ReadData); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both_strobes();
    test_wrap();
    test_operand_hold();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
